// File: rtl/pocket_input_pkg.sv
// Shared pad bit map, ownership encoding and coin FSM states for the Pocket
// input arbiter.
package pocket_input_pkg;
  localparam int NUM_PADS = 2;
  localparam int PAD_W    = 16;
  localparam int BTN_W    = 8;

  localparam int PAD_U  = 0;
  localparam int PAD_D  = 1;
  localparam int PAD_L  = 2;
  localparam int PAD_R  = 3;
  localparam int PAD_A  = 4;
  localparam int PAD_B  = 5;
  localparam int PAD_X  = 6;
  localparam int PAD_Y  = 7;
  localparam int PAD_L1 = 8;
  localparam int PAD_R1 = 9;
  localparam int PAD_L2 = 10;
  localparam int PAD_R2 = 11;
  localparam int PAD_L3 = 12;
  localparam int PAD_R3 = 13;
  localparam int PAD_SE = 14;
  localparam int PAD_ST = 15;

  typedef enum logic [1:0] {
    OWN_FREE = 2'd0,
    OWN_PAD1 = 2'd1,
    OWN_PAD2 = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_PULSE = 2'd1,
    CS_LOCK  = 2'd2
  } coin_st_e;
endpackage

// File: rtl/pocket_coin_pulser.sv
// One coin slot: a SELECT edge becomes a fixed-length pulse followed by a
// lockout window; edges seen outside IDLE are discarded.
module pocket_coin_pulser
  import pocket_input_pkg::*;
#(
  parameter logic [23:0] COIN_PULSE_CYC = 24'd4_000_000,
  parameter logic [23:0] LOCKOUT_CYC    = 24'd8_000_000
) (
  input  logic iCLK,
  input  logic iRESET_N,
  input  logic iEDGE,
  output logic oCOIN
);
  localparam int PW = $clog2(COIN_PULSE_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [PW-1:0] P_LAST = PW'(COIN_PULSE_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOCKOUT_CYC - 1);

  coin_st_e        st;
  logic [PW-1:0]   pcnt;
  logic [LW-1:0]   lcnt;

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      st    <= CS_IDLE;
      pcnt  <= '0;
      lcnt  <= '0;
      oCOIN <= 1'b0;
    end else begin
      case (st)
        CS_IDLE: if (iEDGE) begin
          st    <= CS_PULSE;
          pcnt  <= '0;
          oCOIN <= 1'b1;
        end
        CS_PULSE: if (pcnt == P_LAST) begin
          st    <= CS_LOCK;
          lcnt  <= '0;
          oCOIN <= 1'b0;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
        CS_LOCK: if (lcnt == L_LAST) st <= CS_IDLE;
                 else                lcnt <= lcnt + 1'b1;
        default: begin
          st    <= CS_IDLE;
          oCOIN <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/pocket_input_arbiter.sv
// Maps two synchronised Pocket pad words onto arcade player controls, with
// optional shared ownership of the player-1 slot and timed coin pulses.
module pocket_input_arbiter
  import pocket_input_pkg::*;
#(
  parameter logic [23:0] COIN_PULSE_CYC   = 24'd4_000_000,
  parameter logic [23:0] LOCKOUT_CYC      = 24'd8_000_000,
  parameter logic [27:0] IDLE_TIMEOUT_CYC = 28'd200_000_000
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic [15:0] iJOY1,
  input  logic [15:0] iJOY2,
  input  logic        iSHARE,
  output logic [7:0]  oP1,
  output logic [7:0]  oP2,
  output logic [1:0]  oCOIN,
  output logic [1:0]  oSTART,
  output logic [1:0]  oOWNER
);
  localparam int IW = $clog2(IDLE_TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT_CYC - 1);

  logic [NUM_PADS-1:0][PAD_W-1:0] pad;
  logic [NUM_PADS-1:0][BTN_W-1:0] p_nxt;
  logic [NUM_PADS-1:0]            se_prev, se_rise, pad_act, st_nxt, coin_edge;
  owner_e                         owner_q, owner_nxt;
  logic [IW-1:0]                  idle_cnt, idle_nxt;
  logic                           share_q, route_en, swap, src;

  assign pad[0] = iJOY1;
  assign pad[1] = iJOY2;

  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_act[i] = |pad[i];
      se_rise[i] = pad[i][PAD_SE] & ~se_prev[i];
    end
  end

  always_comb begin
    owner_nxt = owner_q;
    idle_nxt  = idle_cnt;
    if (!iSHARE || (iSHARE != share_q)) begin
      owner_nxt = OWN_FREE;
      idle_nxt  = '0;
    end else begin
      case (owner_q)
        OWN_FREE: begin
          idle_nxt = '0;
          if      (pad_act[0]) owner_nxt = OWN_PAD1;
          else if (pad_act[1]) owner_nxt = OWN_PAD2;
        end
        OWN_PAD1, OWN_PAD2: begin
          if (pad_act[owner_q == OWN_PAD2]) begin
            idle_nxt = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            owner_nxt = OWN_FREE;
            idle_nxt  = '0;
          end else begin
            idle_nxt = idle_cnt + 1'b1;
          end
        end
        default: begin
          owner_nxt = OWN_FREE;
          idle_nxt  = '0;
        end
      endcase
    end
  end

  // Routing follows the next-state owner so a claiming press lands on player 1
  // in the same registered cycle.
  always_comb begin
    route_en = !iSHARE || (owner_nxt != OWN_FREE);
    swap     = iSHARE && (owner_nxt == OWN_PAD2);
    src      = 1'b0;
    for (int i = 0; i < NUM_PADS; i++) begin
      src          = i[0] ^ swap;
      p_nxt[i]     = route_en ? pad[src][BTN_W-1:0] : '0;
      st_nxt[i]    = route_en & pad[src][PAD_ST];
      coin_edge[i] = route_en & se_rise[src];
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      owner_q  <= OWN_FREE;
      idle_cnt <= '0;
      share_q  <= iSHARE;
      se_prev  <= '1;
      oP1      <= '0;
      oP2      <= '0;
      oSTART   <= '0;
    end else begin
      owner_q  <= owner_nxt;
      idle_cnt <= idle_nxt;
      share_q  <= iSHARE;
      se_prev  <= {pad[1][PAD_SE], pad[0][PAD_SE]};
      oP1      <= p_nxt[0];
      oP2      <= p_nxt[1];
      oSTART   <= st_nxt;
    end
  end

  assign oOWNER = owner_q;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_coin
    pocket_coin_pulser #(
      .COIN_PULSE_CYC(COIN_PULSE_CYC),
      .LOCKOUT_CYC   (LOCKOUT_CYC)
    ) u_coin (
      .iCLK    (iCLK),
      .iRESET_N(iRESET_N),
      .iEDGE   (coin_edge[g]),
      .oCOIN   (oCOIN[g])
    );
  end
endmodule

// File: tb/tb_pocket_input_arbiter.sv
// Directed bench: single-cycle vector table for routing/ownership plus
// hand-written sequences for coin timing, idle timeout and reset abort.
module tb_pocket_input_arbiter;
  logic        iCLK = 1'b0;
  logic        iRESET_N;
  logic [15:0] iJOY1, iJOY2;
  logic        iSHARE;
  logic [7:0]  oP1, oP2;
  logic [1:0]  oCOIN, oSTART, oOWNER;

  int checks = 0;
  int failures = 0;

  pocket_input_arbiter #(
    .COIN_PULSE_CYC  (24'd4),
    .LOCKOUT_CYC     (24'd8),
    .IDLE_TIMEOUT_CYC(28'd16)
  ) dut (
    .iCLK    (iCLK),
    .iRESET_N(iRESET_N),
    .iJOY1   (iJOY1),
    .iJOY2   (iJOY2),
    .iSHARE  (iSHARE),
    .oP1     (oP1),
    .oP2     (oP2),
    .oCOIN   (oCOIN),
    .oSTART  (oSTART),
    .oOWNER  (oOWNER)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        rst_n;
    logic        sh;
    logic [15:0] j1;
    logic [15:0] j2;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [1:0]  coin;
    logic [1:0]  st;
    logic [1:0]  own;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic rst_n, input logic sh, input logic [15:0] j1, input logic [15:0] j2);
    iRESET_N = rst_n;
    iSHARE   = sh;
    iJOY1    = j1;
    iJOY2    = j2;
  endtask

  initial begin
    logic exp_c;
    drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);

    //            rst  sh  j1        j2        p1     p2     coin   st     own
    tv[0]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 2'b00, 2'b00, 2'd0};
    tv[1]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 2'b00, 2'b00, 2'd0};
    tv[2]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 8'hFF, 8'h00, 2'b00, 2'b01, 2'd0};
    tv[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 2'b00, 2'd0};
    tv[4]  = '{1'b1, 1'b0, 16'h0000, 16'h8005, 8'h00, 8'h05, 2'b00, 2'b10, 2'd0};
    tv[5]  = '{1'b1, 1'b0, 16'h0033, 16'h0F40, 8'h33, 8'h40, 2'b00, 2'b00, 2'd0};
    tv[6]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 2'b00, 2'd0};
    tv[7]  = '{1'b1, 1'b1, 16'h0000, 16'h0010, 8'h10, 8'h00, 2'b00, 2'b00, 2'd2};
    tv[8]  = '{1'b1, 1'b1, 16'h0001, 16'h0010, 8'h10, 8'h01, 2'b00, 2'b00, 2'd2};
    tv[9]  = '{1'b1, 1'b1, 16'h8001, 16'h0010, 8'h10, 8'h01, 2'b00, 2'b10, 2'd2};
    tv[10] = '{1'b1, 1'b0, 16'h8001, 16'h0010, 8'h01, 8'h10, 2'b00, 2'b01, 2'd0};
    tv[11] = '{1'b1, 1'b1, 16'h0001, 16'h0001, 8'h00, 8'h00, 2'b00, 2'b00, 2'd0};
    tv[12] = '{1'b1, 1'b1, 16'h0001, 16'h0001, 8'h01, 8'h01, 2'b00, 2'b00, 2'd1};
    tv[13] = '{1'b1, 1'b1, 16'h8000, 16'h0000, 8'h00, 8'h00, 2'b00, 2'b01, 2'd1};

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].rst_n, tv[i].sh, tv[i].j1, tv[i].j2);
      step();
      chk($sformatf("vec%0d_p1", i),   32'(oP1),    32'(tv[i].p1));
      chk($sformatf("vec%0d_p2", i),   32'(oP2),    32'(tv[i].p2));
      chk($sformatf("vec%0d_coin", i), 32'(oCOIN),  32'(tv[i].coin));
      chk($sformatf("vec%0d_st", i),   32'(oSTART), 32'(tv[i].st));
      chk($sformatf("vec%0d_own", i),  32'(oOWNER), 32'(tv[i].own));
    end

    // Idle timeout: 15 idle cycles then activity keeps PAD1; 16 idle releases.
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("idle_a%0d_own", k), 32'(oOWNER), 32'd1);
    end
    drive(1'b1, 1'b1, 16'h0002, 16'h0000);
    step();
    chk("idle_keep_own", 32'(oOWNER), 32'd1);
    chk("idle_keep_p1",  32'(oP1),    32'h02);
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("idle_b%0d_own", k), 32'(oOWNER), (k == 16) ? 32'd0 : 32'd1);
    end
    chk("idle_free_p1", 32'(oP1), 32'h00);
    chk("idle_free_p2", 32'(oP2), 32'h00);

    // Coin timing in fixed mode: pulses at 0, 13 and 27; edges at 6, 12-boundary
    // (held 13..20) and 25 fall in PULSE/LOCK and are dropped.
    for (int k = 0; k <= 32; k++) begin
      logic se;
      se = (k == 0) || (k == 6) || (k >= 13 && k <= 20) || (k == 25) || (k == 27);
      drive(1'b1, 1'b0, se ? 16'h4000 : 16'h0000, 16'h0000);
      step();
      exp_c = (k <= 3) || (k >= 13 && k <= 16) || (k >= 27 && k <= 30);
      chk($sformatf("coin_seq%0d", k), 32'(oCOIN), {31'd0, exp_c});
    end

    // Share toggle mid-pulse: ownership drops, both coin pulses still run 4 cycles.
    drive(1'b0, 1'b1, 16'h0000, 16'h0000);
    step();
    step();
    chk("rst_coin", 32'(oCOIN), 32'd0);
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    step();
    drive(1'b1, 1'b1, 16'h4000, 16'h4000);
    step();
    chk("sim_own",  32'(oOWNER), 32'd1);
    chk("sim_coin", 32'(oCOIN),  32'b11);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("tog_own",  32'(oOWNER), 32'd0);
    chk("tog_coin1", 32'(oCOIN), 32'b11);
    step();
    chk("tog_coin2", 32'(oCOIN), 32'b11);
    step();
    chk("tog_coin3", 32'(oCOIN), 32'b11);
    step();
    chk("tog_coin4", 32'(oCOIN), 32'b00);

    // Reset aborts lockout and an in-flight pulse.
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step();
    drive(1'b1, 1'b0, 16'h4000, 16'h0000);
    step();
    chk("post_lock_coin", 32'(oCOIN), 32'b01);
    drive(1'b0, 1'b0, 16'h4000, 16'h0000);
    step();
    chk("mid_rst_coin", 32'(oCOIN), 32'b00);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("after_rst_coin", 32'(oCOIN), 32'b00);
    drive(1'b1, 1'b0, 16'h4000, 16'h0000);
    step();
    chk("rearm_coin", 32'(oCOIN), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pocket_input_arbiter.md
Name: pocket_input_arbiter

Overview:
Sits after the two per-pad synchronisers (16-bit Pocket pad words already in the iCLK domain) and maps them onto arcade player inputs.
- Routes pad 1 / pad 2 onto player 1 / player 2 controls.
- In share mode, arbitrates ownership of the player-1 slot between the two pads, with an idle timeout.
- Turns SELECT presses into timed coin pulses with lockout.
- Turns START into registered start levels.

Parameters:
COIN_PULSE_CYC, 24'd4_000_000, cycles oCOIN stays high per accepted press (>=1)
LOCKOUT_CYC, 24'd8_000_000, cycles after a pulse during which further presses are dropped (>=1)
IDLE_TIMEOUT_CYC, 28'd200_000_000, owner-idle cycles before share-mode ownership is released (>=1)

Ports:
iCLK  in  1  core clock
iRESET_N  in  1  synchronous reset, active low
iJOY1  in  16  pad 1 word, synced; bit map 0 U,1 D,2 L,3 R,4 A,5 B,6 X,7 Y,8 L1,9 R1,10 L2,11 R2,12 L3,13 R3,14 SE,15 ST
iJOY2  in  16  pad 2 word, same map
iSHARE  in  1  0 = fixed mapping, 1 = arbitrated player-1 ownership
oP1  out  8  player 1 {Y,X,B,A,R,L,D,U}
oP2  out  8  player 2, same order
oCOIN  out  2  [0] coin P1, [1] coin P2, timed pulses
oSTART  out  2  [0] start P1, [1] start P2, levels
oOWNER  out  2  ownership: 0 FREE, 1 PAD1, 2 PAD2

Behaviour:
Reset (iRESET_N low at a rising edge of iCLK):
- All outputs 0; owner FSM = FREE; idle counter 0.
- Coin FSMs = IDLE, counters 0.
- Previous-value registers for SE/ST are set to all-ones, so a button held through reset never produces an edge.
- Reset asserted mid-pulse or mid-lockout aborts immediately.

Latency: every output is registered; an iJOY change appears on oP*/oSTART 1 cycle later.

Fixed mode (iSHARE=0):
- pad1[7:0] -> oP1, pad1 ST -> oSTART[0], pad1 SE edge -> coin 0.
- pad2 maps the same way onto oP2, oSTART[1], coin 1.
- oOWNER = 0.

Share mode owner FSM:
- FREE:
  - pad1 any bit set -> PAD1.
  - else pad2 any bit set -> PAD2.
  - Simultaneous activity: pad1 wins.
- PADn:
  - Owner pad drives oP1, oSTART[0] and coin 0; the other pad drives oP2, oSTART[1] and coin 1.
  - Idle counter clears on any owner bit set, otherwise increments.
  - Counter reaching IDLE_TIMEOUT_CYC-1 with owner still idle -> FREE.
- Outputs while in FREE: oP1 = oP2 = 0, oSTART = 0.
- Routing uses the next-state owner, so the pad press that claims ownership routes its own SE/ST/direction to player 1 on the same registered cycle.
- Any change of iSHARE forces FREE and clears the idle counter on the next edge; coin FSMs are unaffected.

Coin FSM (one per player):
- IDLE: rising edge of the routed SE (current 1, previous 0 on the physical pad) -> PULSE.
- PULSE: oCOIN=1 for exactly COIN_PULSE_CYC cycles -> LOCK.
- LOCK: oCOIN=0 for LOCKOUT_CYC cycles -> IDLE.
- Edges arriving in PULSE or LOCK are dropped, not queued.
- Holding SE produces one pulse only.
- Both coins are independent; simultaneous edges give simultaneous pulses.

Counter widths: $clog2(param+1); no counter wraps, each saturates at its terminal value.

Decomposition:
Package pocket_input_pkg:
- Pad bit-index localparams (PAD_U..PAD_ST).
- Owner encoding enum {OWN_FREE=0, OWN_PAD1=1, OWN_PAD2=2}.
- Coin state enum {CS_IDLE, CS_PULSE, CS_LOCK}.

Sub-module pocket_coin_pulser:
- Ports: iCLK, iRESET_N, iEDGE, oCOIN.
- Parameters: COIN_PULSE_CYC, LOCKOUT_CYC.
- Instantiated twice.

Arbitration, routing and edge detection stay in the top level.

Test Plan (COIN_PULSE_CYC=4, LOCKOUT_CYC=8, IDLE_TIMEOUT_CYC=16):
1. Reset with iJOY1=16'hFFFF held, then release reset -> oCOIN=0 throughout, oP1=8'hFF one cycle after reset deasserts, oSTART[0]=1.
2. iSHARE=0, pulse iJOY1[14] for 1 cycle -> oCOIN[0] high exactly 4 cycles starting 1 cycle later. A second SE edge 6 cycles later is dropped; an edge 13+ cycles after the first is accepted.
3. iSHARE=1, iJOY2=16'h0010 then iJOY1=16'h0001 -> oOWNER=2, oP1=8'h10, oP2=8'h01.
4. iSHARE=1, iJOY1 and iJOY2 both 16'h0001 from FREE in the same cycle -> oOWNER=1.
5. Owner PAD1, then iJOY1=0 for 16 cycles -> oOWNER=0 and oP1=0. Activity after 15 idle cycles keeps oOWNER=1.
6. Toggle iSHARE mid-coin-pulse -> oOWNER=0 next cycle; oCOIN pulse still completes 4 cycles. Assert iRESET_N=0 mid-pulse -> oCOIN=0 next edge.
